// File: rtl/exe_stage_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg : shared definitions for the MIPS execute stage.
//   - EXE_CMD operation codes (single-cycle ALU and multi-cycle mul/div)
//   - branch type codes
//   - operand forward-select codes and the forwarding mux helper
//   - md_state_t : multiply/divide sequencer states
// ---------------------------------------------------------------------------
package exe_pkg;

   localparam logic [3:0] CMD_ADD  = 4'b0000;
   localparam logic [3:0] CMD_SUB  = 4'b0010;
   localparam logic [3:0] CMD_AND  = 4'b0100;
   localparam logic [3:0] CMD_OR   = 4'b0101;
   localparam logic [3:0] CMD_NOR  = 4'b0110;
   localparam logic [3:0] CMD_XOR  = 4'b0111;
   localparam logic [3:0] CMD_SLL  = 4'b1000;
   localparam logic [3:0] CMD_SRA  = 4'b1001;
   localparam logic [3:0] CMD_SRL  = 4'b1010;
   localparam logic [3:0] CMD_MUL  = 4'b1100;
   localparam logic [3:0] CMD_DIVU = 4'b1101;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEZ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JMP  = 2'b11;

   localparam logic [1:0] FWD_IDEX     = 2'b00;
   localparam logic [1:0] FWD_MEM      = 2'b01;
   localparam logic [1:0] FWD_WB       = 2'b10;
   localparam logic [1:0] FWD_IDEX_ALT = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // Both 00 and 11 select the ID/EX value.
   function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                           input logic [31:0] idex,
                                           input logic [31:0] mem,
                                           input logic [31:0] wb);
      case (sel)
         FWD_MEM: return mem;
         FWD_WB:  return wb;
         default: return idex;
      endcase
   endfunction

endpackage

// File: rtl/exe_stage_muldiv_md_iter.sv
// ---------------------------------------------------------------------------
// md_iter : iterative multiply / unsigned divide sequencer (IDLE/BUSY/DONE).
//   One shift-add (MUL) or restoring-subtract (DIVU) step per BUSY cycle,
//   MD_CYCLES steps per operation; result is presented in DONE.
// Ports:
//   clk, rst (sync, active-high), flush (sync kill)
//   start  : operation presented (only acted on in IDLE)
//   op     : EXE_CMD code, latched on start
//   a, b   : operands, latched on start
//   busy   : state is BUSY
//   done   : state is DONE, result valid
//   result : latched product (low word) or quotient
// Configuration: `define EXE_DIV_EN to build the divider datapath.
// ---------------------------------------------------------------------------
module md_iter
   import exe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned     CW       = $clog2(MD_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(MD_CYCLES - 1);

   md_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      op_q, op_d;
   // MUL : acc = partial product, x = multiplicand (<<), y = multiplier (>>)
   // DIVU: acc = remainder, x = dividend shifting out / quotient shifting in,
   //       y = divisor
   logic [XLEN-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
   logic [XLEN-1:0] mul_acc, mul_x, mul_y;

   assign mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;
   assign mul_x   = {x_q[XLEN-2:0], 1'b0};
   assign mul_y   = {1'b0, y_q[XLEN-1:1]};

`ifdef EXE_DIV_EN
   logic [XLEN:0] rem_shift, rem_diff;
   assign rem_shift = {acc_q, x_q[XLEN-1]};
   // Bit XLEN of the difference is the borrow: set means restore.
   assign rem_diff  = rem_shift - {1'b0, y_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = '0;
               op_d    = op;
               acc_d   = '0;
               x_d     = a;
               y_d     = b;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = MD_DONE;
`ifdef EXE_DIV_EN
            if (op_q == CMD_DIVU) begin
               if (!rem_diff[XLEN]) begin
                  acc_d = rem_diff[XLEN-1:0];
                  x_d   = {x_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = rem_shift[XLEN-1:0];
                  x_d   = {x_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_d = mul_acc;
               x_d   = mul_x;
               y_d   = mul_y;
            end
`else
            acc_d = mul_acc;
            x_d   = mul_x;
            y_d   = mul_y;
`endif
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (flush) begin
         state_d = MD_IDLE;
         cnt_d   = '0;
         op_d    = '0;
         acc_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign busy = (state_q == MD_BUSY);
   assign done = (state_q == MD_DONE);

`ifdef EXE_DIV_EN
   assign result = (op_q == CMD_DIVU) ? x_q : acc_q;
`else
   assign result = (op_q == CMD_MUL) ? acc_q : '0;
`endif

endmodule

// File: rtl/exe_stage_muldiv.sv
// ---------------------------------------------------------------------------
// exe_stage_muldiv : execute stage of the 5-stage MIPS pipeline.
//   Operand forwarding, single-cycle ALU, branch decision/target, and an
//   iterative multiply/divide unit that stalls upstream while busy.
// Ports:
//   clk, rst (sync, active-high), flush (kills in-flight mul/div)
//   exe_cmd, val1, val2, reg2, pc_in, br_type, is_imm : from ID/EX
//   mem_r_en_in, mem_w_en_in, wb_en_in                 : control from ID/EX
//   sel_a, sel_b, sel_st, fwd_mem, fwd_wb              : forwarding
//   alu_result, st_data, br_addr, br_taken             : to EX/MEM / PC
//   mem_r_en, mem_w_en, wb_en                          : control, bubbled on stall
//   stall                                              : freeze IF/ID/ID-EX/PC
// Configuration: `define EXE_DIV_EN enables DIVU (code 1101); otherwise that
//   code behaves as an unknown single-cycle command.
// ---------------------------------------------------------------------------
module exe_stage_muldiv
   import exe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [3:0]      exe_cmd,
   input  logic [XLEN-1:0] val1,
   input  logic [XLEN-1:0] val2,
   input  logic [XLEN-1:0] reg2,
   input  logic [XLEN-1:0] pc_in,
   input  logic [1:0]      br_type,
   input  logic            is_imm,
   input  logic            mem_r_en_in,
   input  logic            mem_w_en_in,
   input  logic            wb_en_in,
   input  logic [1:0]      sel_a,
   input  logic [1:0]      sel_b,
   input  logic [1:0]      sel_st,
   input  logic [XLEN-1:0] fwd_mem,
   input  logic [XLEN-1:0] fwd_wb,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] st_data,
   output logic [XLEN-1:0] br_addr,
   output logic            br_taken,
   output logic            mem_r_en,
   output logic            mem_w_en,
   output logic            wb_en,
   output logic            stall
);

   logic [XLEN-1:0] a, b, alu_out, md_result;
   logic            md_start, md_busy, md_done, br_cond;

   assign a       = fwd_sel(sel_a, val1, fwd_mem, fwd_wb);
   assign b       = is_imm ? val2 : fwd_sel(sel_b, val2, fwd_mem, fwd_wb);
   assign st_data = fwd_sel(sel_st, reg2, fwd_mem, fwd_wb);

`ifdef EXE_DIV_EN
   assign md_start = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_DIVU);
`else
   assign md_start = (exe_cmd == CMD_MUL);
`endif

   md_iter #(
      .XLEN      (XLEN),
      .MD_CYCLES (MD_CYCLES)
   ) u_md_iter (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .start  (md_start),
      .op     (exe_cmd),
      .a      (a),
      .b      (b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // The mul/div opcode is still in ID/EX during DONE; it must not restart
   // the unit or stall, so the IDLE-cycle stall is qualified by ~md_done.
   assign stall = md_busy | (md_start & ~md_done);

   always_comb begin
      alu_out = '0;
      case (exe_cmd)
         CMD_ADD: alu_out = a + b;
         CMD_SUB: alu_out = a - b;
         CMD_AND: alu_out = a & b;
         CMD_OR:  alu_out = a | b;
         CMD_NOR: alu_out = ~(a | b);
         CMD_XOR: alu_out = a ^ b;
         CMD_SLL: alu_out = a << b[4:0];
         CMD_SRA: alu_out = $signed(a) >>> b[4:0];
         CMD_SRL: alu_out = a >> b[4:0];
         default: alu_out = '0;
      endcase
   end

   assign alu_result = md_done ? md_result : alu_out;

   assign br_addr = pc_in + {b[XLEN-3:0], 2'b00};

   always_comb begin
      br_cond = 1'b0;
      case (br_type)
         BR_BEZ:  br_cond = (a == '0);
         BR_BNE:  br_cond = (a != st_data);
         BR_JMP:  br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   assign br_taken = br_cond & ~stall;
   assign mem_r_en = mem_r_en_in & ~stall;
   assign mem_w_en = mem_w_en_in & ~stall;
   assign wb_en    = wb_en_in & ~stall;

endmodule

// File: tb/tb_exe_stage_muldiv.sv
module tb_exe_stage_muldiv;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [3:0]  exe_cmd;
   logic [31:0] val1, val2, reg2, pc_in;
   logic [1:0]  br_type;
   logic        is_imm, mem_r_en_in, mem_w_en_in, wb_en_in;
   logic [1:0]  sel_a, sel_b, sel_st;
   logic [31:0] fwd_mem, fwd_wb;
   logic [31:0] alu_result, st_data, br_addr;
   logic        br_taken, mem_r_en, mem_w_en, wb_en, stall;

   int checks = 0;
   int errors = 0;

   exe_stage_muldiv #(.XLEN(32), .MD_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .exe_cmd(exe_cmd),
      .val1(val1), .val2(val2), .reg2(reg2), .pc_in(pc_in),
      .br_type(br_type), .is_imm(is_imm),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
      .sel_a(sel_a), .sel_b(sel_b), .sel_st(sel_st),
      .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
      .alu_result(alu_result), .st_data(st_data), .br_addr(br_addr),
      .br_taken(br_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .wb_en(wb_en), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

`ifdef EXE_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   // ---------------- reference model ----------------
   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] id,
                                        input logic [31:0] m, input logic [31:0] w);
      if (s == 2'b01) return m;
      if (s == 2'b10) return w;
      return id;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] x,
                                           input logic [31:0] y);
      logic signed [31:0] sx;
      int unsigned sh;
      sx = x;
      sh = y % 32;
      case (cmd)
         4'd0:    return x + y;
         4'd2:    return x - y;
         4'd4:    return x & y;
         4'd5:    return x | y;
         4'd6:    return ~(x | y);
         4'd7:    return x ^ y;
         4'd8:    return x << sh;
         4'd9:    return sx >>> sh;
         4'd10:   return x >> sh;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [3:0] cmd, input logic [31:0] x,
                                          input logic [31:0] y);
      longint sx, sy, p;
      if (cmd == 4'd12) begin
         sx = $signed(x);
         sy = $signed(y);
         p  = sx * sy;
         return p[31:0];
      end
      if (y == 32'd0) return 32'hFFFF_FFFF;
      return x / y;
   endfunction

   function automatic logic ref_br(input logic [1:0] bt, input logic [31:0] x,
                                   input logic [31:0] st);
      case (bt)
         2'd1:    return x == 32'd0;
         2'd2:    return x != st;
         2'd3:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_idle();
      flush = 0; exe_cmd = 4'd0; val1 = 0; val2 = 0; reg2 = 0; pc_in = 0;
      br_type = 0; is_imm = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
      sel_a = 0; sel_b = 0; sel_st = 0; fwd_mem = 0; fwd_wb = 0;
   endtask

   // Presents a mul/div, counts stall cycles (bounded), checks the bubble,
   // then checks the DONE-cycle result and moves ID/EX on at the DONE edge.
   task automatic run_md(input logic [3:0] cmd, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] bt, input bit use_fwd);
      int n;
      logic [31:0] exp;
      @(negedge clk);
      set_idle();
      exe_cmd = cmd; val2 = bv; br_type = bt; reg2 = $urandom; pc_in = $urandom;
      wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1;
      if (use_fwd) begin sel_a = 2'b01; fwd_mem = av; val1 = $urandom; end
      else val1 = av;
      exp = ref_md(cmd, av, bv);
      #1;
      n = 0;
      while (stall === 1'b1 && n < 40) begin
         n++;
         checks++;
         if ({wb_en, mem_r_en, mem_w_en, br_taken} !== 4'b0000) begin
            errors++;
            $display("FAIL md_bubble cyc=%0d got=%b exp=0000", n, {wb_en, mem_r_en, mem_w_en, br_taken});
         end
         @(negedge clk);
         fwd_mem = $urandom; fwd_wb = $urandom;
         #1;
      end
      checks++;
      if (n != 33) begin
         errors++;
         $display("FAIL md_stall_len cmd=%h got=%0d exp=33", cmd, n);
      end
      checks++;
      if (alu_result !== exp) begin
         errors++;
         $display("FAIL md_result cmd=%h a=%h b=%h got=%h exp=%h", cmd, av, bv, alu_result, exp);
      end
      checks++;
      if (wb_en !== 1'b1) begin
         errors++;
         $display("FAIL md_done_wb got=%b exp=1", wb_en);
      end
      @(posedge clk);
      #1;
      set_idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle();
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({stall, wb_en, mem_r_en, mem_w_en, br_taken} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=00000", {stall, wb_en, mem_r_en, mem_w_en, br_taken});
      end
      checks++;
      if (alu_result !== 32'd0) begin
         errors++;
         $display("FAIL reset_result got=%h exp=0", alu_result);
      end
      rst = 0;
   endtask

   task automatic test_alu_directed();
      @(negedge clk);
      set_idle();
      exe_cmd = 4'd0; val1 = 7; val2 = -3; wb_en_in = 1;
      #1;
      checks++;
      if ({alu_result, stall, wb_en} !== {32'd4, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_direct got=%h/%b/%b exp=4/0/1", alu_result, stall, wb_en);
      end
      @(negedge clk);
      exe_cmd = 4'd2; sel_a = 2'b01; fwd_mem = 100; val1 = 5; val2 = 1; wb_en_in = 0;
      #1;
      checks++;
      if ({alu_result, wb_en} !== {32'd99, 1'b0}) begin
         errors++;
         $display("FAIL sub_fwd got=%h/%b exp=63/0", alu_result, wb_en);
      end
      @(negedge clk);
      is_imm = 1; sel_b = 2'b10; fwd_wb = 32'd999;
      #1;
      checks++;
      if (alu_result !== 32'd99) begin
         errors++;
         $display("FAIL sub_imm got=%h exp=63", alu_result);
      end
   endtask

   task automatic test_alu_random();
      logic [31:0] ea, eb, est;
      int unsigned c;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         c = $urandom_range(0, 15);
         if (c == 12 || (DIV_ON && c == 13)) c = 0;
         exe_cmd = c[3:0];
         val1 = $urandom; val2 = $urandom; reg2 = $urandom; pc_in = $urandom;
         fwd_mem = $urandom; fwd_wb = $urandom;
         if ($urandom_range(0, 3) == 0) val1 = 0;
         if ($urandom_range(0, 3) == 0) reg2 = val1;
         sel_a = $urandom; sel_b = $urandom; sel_st = $urandom; is_imm = $urandom;
         br_type = $urandom; mem_r_en_in = $urandom; mem_w_en_in = $urandom; wb_en_in = $urandom;
         ea  = pick(sel_a, val1, fwd_mem, fwd_wb);
         eb  = is_imm ? val2 : pick(sel_b, val2, fwd_mem, fwd_wb);
         est = pick(sel_st, reg2, fwd_mem, fwd_wb);
         #1;
         checks++;
         if (alu_result !== ref_alu(exe_cmd, ea, eb)) begin
            errors++;
            $display("FAIL alu_rand cmd=%h a=%h b=%h got=%h exp=%h", exe_cmd, ea, eb, alu_result, ref_alu(exe_cmd, ea, eb));
         end
         checks++;
         if (st_data !== est) begin
            errors++;
            $display("FAIL st_data got=%h exp=%h", st_data, est);
         end
         checks++;
         if (br_addr !== pc_in + eb * 4) begin
            errors++;
            $display("FAIL br_addr got=%h exp=%h", br_addr, pc_in + eb * 4);
         end
         checks++;
         if (br_taken !== ref_br(br_type, ea, est)) begin
            errors++;
            $display("FAIL br_taken bt=%0d got=%b exp=%b", br_type, br_taken, ref_br(br_type, ea, est));
         end
         checks++;
         if ({stall, mem_r_en, mem_w_en, wb_en} !== {1'b0, mem_r_en_in, mem_w_en_in, wb_en_in}) begin
            errors++;
            $display("FAIL ctrl_pass got=%b exp=%b", {stall, mem_r_en, mem_w_en, wb_en}, {1'b0, mem_r_en_in, mem_w_en_in, wb_en_in});
         end
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_mul();
      run_md(4'd12, -6, 7, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) run_md(4'd12, $urandom, $urandom, 2'd0, bit'(i % 2));
   endtask

   task automatic test_divu();
      if (DIV_ON) begin
         run_md(4'd13, 100, 7, 2'd0, 1'b0);
         run_md(4'd13, 5, 0, 2'd0, 1'b0);
         run_md(4'd13, 32'hFFFF_FFFF, 1, 2'd0, 1'b1);
         for (int i = 0; i < 4; i++) run_md(4'd13, $urandom, $urandom_range(0, 1000), 2'd0, bit'(i % 2));
      end else begin
         @(negedge clk);
         set_idle();
         exe_cmd = 4'd13; val1 = 100; val2 = 7; wb_en_in = 1;
         #1;
         checks++;
         if ({alu_result, stall, wb_en} !== {32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL divu_off got=%h/%b/%b exp=0/0/1", alu_result, stall, wb_en);
         end
         @(negedge clk); #1;
         checks++;
         if ({alu_result, stall} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL divu_off_next got=%h/%b exp=0/0", alu_result, stall);
         end
         set_idle();
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      set_idle();
      exe_cmd = 4'd12; val1 = -6; val2 = 7; wb_en_in = 1;
      repeat (11) @(negedge clk);
      flush = 1; exe_cmd = 4'd0; val1 = 20; val2 = 22;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_busy got=%b exp=1", stall);
      end
      @(negedge clk);
      flush = 0;
      #1;
      checks++;
      if ({stall, alu_result, wb_en} !== {1'b0, 32'd42, 1'b1}) begin
         errors++;
         $display("FAIL flush_after got=%b/%h/%b exp=0/2a/1", stall, alu_result, wb_en);
      end
      @(negedge clk); #1;
      checks++;
      if ({stall, alu_result} !== {1'b0, 32'd42}) begin
         errors++;
         $display("FAIL flush_idle got=%b/%h exp=0/2a", stall, alu_result);
      end
      set_idle();
      run_md(4'd12, 123, -4, 2'd0, 1'b0);
      // synchronous reset in the middle of an operation
      @(negedge clk);
      exe_cmd = 4'd12; val1 = 9; val2 = 9;
      repeat (6) @(negedge clk);
      rst = 1; exe_cmd = 4'd0; val1 = 1; val2 = 2;
      @(negedge clk);
      rst = 0;
      #1;
      checks++;
      if ({stall, alu_result} !== {1'b0, 32'd3}) begin
         errors++;
         $display("FAIL rst_mid got=%b/%h exp=0/3", stall, alu_result);
      end
      set_idle();
      run_md(4'd12, 11, 13, 2'd0, 1'b0);
   endtask

   task automatic test_branch();
      @(negedge clk);
      set_idle();
      br_type = 2'd2; val1 = 3; reg2 = 4; pc_in = 32'h40; val2 = 2;
      #1;
      checks++;
      if ({br_taken, br_addr} !== {1'b1, 32'h48}) begin
         errors++;
         $display("FAIL bne_taken got=%b/%h exp=1/48", br_taken, br_addr);
      end
      @(negedge clk);
      reg2 = 3;
      #1;
      checks++;
      if (br_taken !== 1'b0) begin
         errors++;
         $display("FAIL bne_equal got=%b exp=0", br_taken);
      end
      @(negedge clk);
      br_type = 2'd1; val1 = 0;
      #1;
      checks++;
      if (br_taken !== 1'b1) begin
         errors++;
         $display("FAIL bez_zero got=%b exp=1", br_taken);
      end
      set_idle();
      // BEZ with a==0 on a stalling MUL: run_md checks br_taken stays 0
      run_md(4'd12, 0, 5, 2'd1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_md(4'd12, $urandom, $urandom, 2'd3, 1'b0);
      if (DIV_ON) run_md(4'd13, $urandom, $urandom_range(1, 50), 2'd0, 1'b0);
      run_md(4'd12, $urandom, $urandom, 2'd0, 1'b1);
      @(negedge clk);
      exe_cmd = 4'd7; val1 = 32'hF0F0_0000; val2 = 32'h0FF0_1234; wb_en_in = 1;
      #1;
      checks++;
      if ({stall, alu_result} !== {1'b0, 32'hFF00_1234}) begin
         errors++;
         $display("FAIL b2b_xor got=%b/%h exp=0/ff001234", stall, alu_result);
      end
      set_idle();
   endtask

   initial begin
      rst = 1;
      set_idle();
      test_reset();
      test_alu_directed();
      test_alu_random();
      test_mul();
      test_divu();
      test_flush();
      test_branch();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage_muldiv.md
Name: exe_stage_muldiv

Overview:
Execute stage of the 5-stage MIPS pipeline. Sits between the ID/EX pipeline register and the EX/MEM register.
- Applies operand forwarding and computes the single-cycle ALU result, branch decision and branch target.
- Runs iterative 32-cycle multiply/divide operations, freezing the upstream stages while busy and presenting a bubble downstream.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- MD_CYCLES, 32, iterations per multiply/divide (must equal XLEN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill the in-flight multiply/divide; synchronous.
- exe_cmd  in  4  operation code from ID/EX.
- val1, val2, reg2  in  32 each  operands and store data from ID/EX.
- pc_in  in  32  PC+4 of the instruction.
- br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- is_imm  in  1  val2 is an immediate (blocks val2 forwarding).
- mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control bits.
- sel_a, sel_b, sel_st  in  2 each  forward select: 00 ID/EX value, 01 fwd_mem, 10 fwd_wb, 11 ID/EX value.
- fwd_mem, fwd_wb  in  32 each  forwarded results.
- alu_result  out  32  result to EX/MEM.
- st_data  out  32  forwarded store data.
- br_addr  out  32  branch target.
- br_taken  out  1  redirect the PC.
- mem_r_en, mem_w_en, wb_en  out  1 each  control bits, gated by stall.
- stall  out  1  freezes IF/ID/ID-EX registers and the PC.

Behaviour:
- Operands:
  - a = mux(sel_a, val1).
  - b = is_imm ? val2 : mux(sel_b, val2).
  - st_data = mux(sel_st, reg2).
- Single-cycle commands (combinational, zero latency):
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shift amount is b[4:0].
  - Any other non-multiply/divide code: alu_result=0.
- Arithmetic is modulo 2^32; there are no overflow flags.
- Branch:
  - br_addr = pc_in + {b[29:0],2'b00}.
  - br_taken = (BEZ & a==0) | (BNE & a!=st_data) | JMP, forced 0 while stall=1.
- Multi-cycle commands:
  - 1100 MUL: signed, low 32 bits of the product.
  - 1101 DIVU: unsigned quotient.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - If exe_cmd is MUL/DIVU: stall=1 combinationally, latch a/b and the opcode, cnt=0, go to BUSY.
    - Otherwise stall=0.
  - BUSY: stall=1; one shift-add or restoring-subtract step per cycle; cnt++. At cnt==MD_CYCLES-1, go to DONE.
  - DONE: stall=0, alu_result=latched result; next state is IDLE.
  - The ID/EX register captures the next instruction at the DONE edge.
- Timing:
  - Total stall is 1+MD_CYCLES = 33 cycles.
  - The result reaches EX/MEM on the 34th edge after the operation is presented.
- While stall=1: mem_r_en=mem_w_en=wb_en=0 (bubble); otherwise they pass through.
- Forwarded inputs are ignored after latching.
- DIVU by zero: quotient=32'hFFFF_FFFF, with the same 33-cycle latency.
- rst or flush in any state: FSM goes to IDLE, cnt=0, latched operands=0. The flush takes effect at that edge.
- Reset values of outputs derived from state: stall=0, all gated enables=0.
- The FSM state is never X after reset.

Optional Feature:
- Macro EXE_DIV_EN.
- Defined: DIVU is implemented as above.
- Undefined:
  - Code 1101 is treated as an unknown single-cycle command: alu_result=0, no stall.
  - Divider logic is absent; MUL is unchanged.

Decomposition:
- Shared package exe_pkg:
  - EXE_CMD code constants.
  - br_type constants.
  - forward select codes.
  - md_state_t enum (IDLE/BUSY/DONE).
- Sub-module md_iter: the FSM, counter and shift-add/restoring-divide datapath.
  - Inputs: start, op, a, b, flush.
  - Outputs: busy, done, result.
- The top level holds the forwarding muxes, ALU, branch logic and control gating.

Test Plan:
- ADD with a=7, b=-3, all sel=00 -> alu_result=4, stall=0, wb_en follows wb_en_in in the same cycle.
- sel_a=01, fwd_mem=100, val1=5, SUB with b=1 -> alu_result=99; with is_imm=1 and sel_b=10, b=val2 (forwarding ignored).
- MUL a=-6, b=7 -> stall high for exactly 33 cycles, wb_en=0 throughout, then alu_result=-42 (32'hFFFF_FFD6) with stall=0.
- DIVU 100/7 -> 14; DIVU 5/0 -> 32'hFFFF_FFFF; with EXE_DIV_EN undefined, DIVU -> 0 and no stall.
- flush asserted at BUSY cnt=10 -> next cycle stall=0, state IDLE; a following ADD completes normally.
- BNE with a=3, st_data=4, pc_in=0x40, b=2 -> br_taken=1, br_addr=0x48; BEZ presented while a MUL is stalling -> br_taken=0.
